layer_mem_arbiter: RTL and testbench

LAYER_MEM_ARBITER -- requirements
Module: layer_mem_arbiter

---
 rtl/layer_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_layer_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mem_arbiter.sv
// Two-requester round-robin arbiter with grant locking and a starvation guard,
// driving a layered memory through registered commands; reads return two cycles after grant.
module layer_mem_arbiter #(
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic        r0_lock,
   input  logic [2:0]  r0_sel,
   input  logic [11:0] r0_addr,
   input  logic [19:0] r0_wdata,
   output logic        r0_gnt,
   output logic        r0_rvalid,
   output logic [19:0] r0_rdata,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic        r1_lock,
   input  logic [2:0]  r1_sel,
   input  logic [11:0] r1_addr,
   input  logic [19:0] r1_wdata,
   output logic        r1_gnt,
   output logic        r1_rvalid,
   output logic [19:0] r1_rdata,
   output logic [2:0]  csel,
   output logic        cwr,
   output logic [11:0] caddr_wr,
   output logic [19:0] cdata_wr,
   output logic        crd,
   output logic [11:0] caddr_rd,
   input  logic [19:0] cdata_rd,
   output logic        busy,
   output logic        err
);
   localparam int unsigned   CW         = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
   localparam logic [2:0]    SEL_L0     = 3'b001;
   localparam logic [2:0]    SEL_L1     = 3'b011;

   typedef enum logic [1:0] {ARB, OWN0, OWN1} state_e;

   state_e        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   logic          gnt0, gnt1, gnt_any;

   logic [2:0]    g_sel;
   logic          g_we, g_legal;
   logic [11:0]   g_addr;
   logic [19:0]   g_wdata;

   logic [2:0]    csel_q;
   logic          cwr_q, crd_q, err_q, rd_owner_q;
   logic [11:0]   caddr_wr_q, caddr_rd_q;
   logic [19:0]   cdata_wr_q;
   logic          r0_rvalid_q, r1_rvalid_q;
   logic [19:0]   r0_rdata_q, r1_rdata_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      lock_cnt_d   = lock_cnt_q;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      unique case (state_q)
         ARB: begin
            if (r0_req && (!r1_req || last_grant_q)) gnt0 = 1'b1;
            else if (r1_req)                         gnt1 = 1'b1;
         end
         OWN0: begin
            if (r0_req && !(lock_cnt_q == LOCK_MAX_C && r1_req)) begin
               gnt0 = 1'b1;
            end else begin
               state_d      = ARB;
               lock_cnt_d   = '0;
               last_grant_d = 1'b0;
            end
         end
         OWN1: begin
            if (r1_req && !(lock_cnt_q == LOCK_MAX_C && r0_req)) begin
               gnt1 = 1'b1;
            end else begin
               state_d      = ARB;
               lock_cnt_d   = '0;
               last_grant_d = 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
      if (reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
      if (gnt0 || gnt1) begin
         last_grant_d = gnt1;
         if (gnt1 ? r1_lock : r0_lock) begin
            state_d    = gnt1 ? OWN1 : OWN0;
            lock_cnt_d = (lock_cnt_q == LOCK_MAX_C) ? lock_cnt_q : lock_cnt_q + CW'(1);
         end else begin
            state_d    = ARB;
            lock_cnt_d = '0;
         end
      end
   end

   assign gnt_any = gnt0 | gnt1;
   assign g_sel   = gnt1 ? r1_sel   : r0_sel;
   assign g_we    = gnt1 ? r1_we    : r0_we;
   assign g_addr  = gnt1 ? r1_addr  : r0_addr;
   assign g_wdata = gnt1 ? r1_wdata : r0_wdata;
   assign g_legal = (g_sel == SEL_L0) || (g_sel == SEL_L1);

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the datapath registers are reset too, since their reset values are visible on ports.
         state_q      <= ARB;
         last_grant_q <= 1'b1;
         lock_cnt_q   <= '0;
         csel_q       <= '0;
         cwr_q        <= 1'b0;
         crd_q        <= 1'b0;
         err_q        <= 1'b0;
         rd_owner_q   <= 1'b0;
         caddr_wr_q   <= '0;
         caddr_rd_q   <= '0;
         cdata_wr_q   <= '0;
         r0_rvalid_q  <= 1'b0;
         r1_rvalid_q  <= 1'b0;
         r0_rdata_q   <= '0;
         r1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         lock_cnt_q   <= lock_cnt_d;
         cwr_q        <= gnt_any && g_legal && g_we;
         crd_q        <= gnt_any && g_legal && !g_we;
         err_q        <= gnt_any && !g_legal;
         // An illegal select still consumes the grant but parks csel at zero.
         if (gnt_any) begin
            csel_q <= g_legal ? g_sel : 3'b000;
            if (g_legal && g_we) begin
               caddr_wr_q <= g_addr;
               cdata_wr_q <= g_wdata;
            end
            if (g_legal && !g_we) begin
               caddr_rd_q <= g_addr;
               rd_owner_q <= gnt1;
            end
         end
         r0_rvalid_q <= crd_q && !rd_owner_q;
         r1_rvalid_q <= crd_q && rd_owner_q;
         if (crd_q && !rd_owner_q) r0_rdata_q <= cdata_rd;
         if (crd_q && rd_owner_q)  r1_rdata_q <= cdata_rd;
      end
   end

   assign r0_gnt    = gnt0;
   assign r1_gnt    = gnt1;
   assign r0_rvalid = r0_rvalid_q;
   assign r1_rvalid = r1_rvalid_q;
   assign r0_rdata  = r0_rdata_q;
   assign r1_rdata  = r1_rdata_q;
   assign csel      = csel_q;
   assign cwr       = cwr_q;
   assign crd       = crd_q;
   assign caddr_wr  = caddr_wr_q;
   assign caddr_rd  = caddr_rd_q;
   assign cdata_wr  = cdata_wr_q;
   assign err       = err_q;
   assign busy      = cwr_q | crd_q | r0_rvalid_q | r1_rvalid_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Scoreboard bench: the driver predicts grants and memory-side responses from a transaction
// model and queues them; a monitor compares the DUT outputs cycle by cycle.
module tb_layer_mem_arbiter;
   localparam int LM = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
   logic [2:0]  r0_sel, r1_sel;
   logic [11:0] r0_addr, r1_addr;
   logic [19:0] r0_wdata, r1_wdata;
   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [19:0] r0_rdata, r1_rdata;
   logic [2:0]  csel;
   logic        cwr, crd, busy, err;
   logic [11:0] caddr_wr, caddr_rd;
   logic [19:0] cdata_wr, cdata_rd;

   typedef struct {
      int          at;
      logic        rst, cwr, crd, err;
      logic [2:0]  csel;
      logic [11:0] aw, ar;
      logic [19:0] dw;
   } cmd_t;

   typedef struct {
      int          at;
      int          port;
      logic [19:0] data;
   } rd_t;

   cmd_t cmd_q[$];
   rd_t  rd_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // transaction-level arbiter and memory-side model
   int          m_owner, m_last, m_cnt;
   logic [2:0]  h_csel;
   logic [11:0] h_aw, h_ar;
   logic [19:0] h_dw;

   always #5 clk = ~clk;

   function automatic logic [19:0] mem_val(input logic [2:0] s, input logic [11:0] a);
      return {a[7:0] ^ 8'h5C, a} ^ {17'h0, s};
   endfunction

   assign cdata_rd = crd ? mem_val(csel, caddr_rd) : 20'hDEAD0;

   layer_mem_arbiter #(.LOCK_MAX(LM)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_sel(r0_sel),
      .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
      .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_sel(r1_sel),
      .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
      .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
      .busy(busy), .err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [1:0] rq, input logic [1:0] we,
                        input logic [1:0] lk, input logic [2:0] s0, input logic [2:0] s1,
                        input logic [11:0] a0, input logic [11:0] a1,
                        input logic [19:0] d0, input logic [19:0] d1);
      int          g;
      cmd_t        e;
      rd_t         r;
      logic [2:0]  gs;
      logic [11:0] ga;
      logic [19:0] gd;
      logic        gw;
      @(negedge clk);
      reset = rst;
      r0_req = rq[0]; r0_we = we[0]; r0_lock = lk[0]; r0_sel = s0; r0_addr = a0; r0_wdata = d0;
      r1_req = rq[1]; r1_we = we[1]; r1_lock = lk[1]; r1_sel = s1; r1_addr = a1; r1_wdata = d1;
      #1;
      g     = -1;
      e.at  = cyc + 1;
      e.rst = rst;
      e.cwr = 1'b0;
      e.crd = 1'b0;
      e.err = 1'b0;
      if (rst) begin
         m_owner = -1; m_last = 1; m_cnt = 0;
         h_csel = '0; h_aw = '0; h_ar = '0; h_dw = '0;
         rd_q.delete();
      end else begin
         if (m_owner < 0) begin
            if (rq[0] && rq[1]) g = 1 - m_last;
            else if (rq[0])     g = 0;
            else if (rq[1])     g = 1;
         end else if (!rq[m_owner]) begin
            m_owner = -1; m_cnt = 0;
         end else if (m_cnt == LM && rq[1 - m_owner]) begin
            m_last = m_owner; m_owner = -1; m_cnt = 0;
         end else begin
            g = m_owner;
         end
         if (g >= 0) begin
            m_last = g;
            if (lk[g]) begin
               m_owner = g;
               m_cnt   = (m_cnt < LM) ? m_cnt + 1 : LM;
            end else begin
               m_owner = -1;
               m_cnt   = 0;
            end
            gs = (g == 1) ? s1 : s0;
            ga = (g == 1) ? a1 : a0;
            gd = (g == 1) ? d1 : d0;
            gw = we[g];
            if (gs == 3'b001 || gs == 3'b011) begin
               h_csel = gs;
               if (gw) begin
                  e.cwr = 1'b1; h_aw = ga; h_dw = gd;
               end else begin
                  e.crd  = 1'b1; h_ar = ga;
                  r.at   = cyc + 2;
                  r.port = g;
                  r.data = mem_val(gs, ga);
                  rd_q.push_back(r);
               end
            end else begin
               h_csel = 3'b000;
               e.err  = 1'b1;
            end
         end
      end
      e.csel = h_csel; e.aw = h_aw; e.ar = h_ar; e.dw = h_dw;
      check("r0_gnt", r0_gnt, g == 0);
      check("r1_gnt", r1_gnt, g == 1);
      cmd_q.push_back(e);
   endtask

   task automatic idle();
      drive(1'b0, 2'b00, 2'b00, 2'b00, 3'b001, 3'b001, 12'h0, 12'h0, 20'h0, 20'h0);
   endtask

   initial begin : monitor
      cmd_t        e;
      rd_t         r;
      logic        rv0, rv1;
      logic [19:0] exp_rd0, exp_rd1;
      exp_rd0 = '0;
      exp_rd1 = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (cmd_q.size() > 0 && cmd_q[0].at == cyc) begin
            e   = cmd_q.pop_front();
            rv0 = 1'b0;
            rv1 = 1'b0;
            if (e.rst) begin
               exp_rd0 = '0;
               exp_rd1 = '0;
            end
            if (rd_q.size() > 0 && rd_q[0].at == cyc) begin
               r = rd_q.pop_front();
               if (r.port == 0) begin rv0 = 1'b1; exp_rd0 = r.data; end
               else             begin rv1 = 1'b1; exp_rd1 = r.data; end
            end
            check("cwr", cwr, e.cwr);
            check("crd", crd, e.crd);
            check("err", err, e.err);
            check("csel", csel, e.csel);
            check("caddr_wr", caddr_wr, e.aw);
            check("cdata_wr", cdata_wr, e.dw);
            check("caddr_rd", caddr_rd, e.ar);
            check("r0_rvalid", r0_rvalid, rv0);
            check("r1_rvalid", r1_rvalid, rv1);
            check("r0_rdata", r0_rdata, exp_rd0);
            check("r1_rdata", r1_rdata, exp_rd1);
            check("busy", busy, e.cwr | e.crd | rv0 | rv1);
         end else if (cmd_q.size() > 0 && cmd_q[0].at < cyc) begin
            check("scoreboard_order", cmd_q[0].at, cyc);
            void'(cmd_q.pop_front());
         end
      end
   end

   initial begin : stimulus
      logic [11:0] burst_a [4];
      logic [1:0]  rq, we, lk;
      logic [2:0]  s0, s1;
      int          k;
      burst_a[0] = 12'h040; burst_a[1] = 12'h041; burst_a[2] = 12'h080; burst_a[3] = 12'h081;
      reset = 1'b1;
      r0_req = 1'b0; r0_we = 1'b0; r0_lock = 1'b0; r0_sel = '0; r0_addr = '0; r0_wdata = '0;
      r1_req = 1'b0; r1_we = 1'b0; r1_lock = 1'b0; r1_sel = '0; r1_addr = '0; r1_wdata = '0;

      // requests held high through reset must not be granted
      repeat (3) drive(1'b1, 2'b11, 2'b00, 2'b11, 3'b001, 3'b011, 12'h111, 12'h222, 20'h0, 20'h0);

      // contention: alternating reads
      for (int i = 0; i < 8; i++)
         drive(1'b0, 2'b11, 2'b00, 2'b00, 3'b001, 3'b011,
               12'($urandom), 12'($urandom), 20'h0, 20'h0);

      // locked burst from r1 while r0 keeps asking
      drive(1'b0, 2'b01, 2'b00, 2'b00, 3'b001, 3'b001, 12'h010, 12'h0, 20'h0, 20'h0);
      for (int i = 0; i < 4; i++)
         drive(1'b0, 2'b11, 2'b00, {(i != 3), 1'b0}, 3'b011, 3'b001,
               12'h500 + 12'(i), burst_a[i], 20'h0, 20'h0);
      drive(1'b0, 2'b01, 2'b00, 2'b00, 3'b011, 3'b001, 12'h5AA, 12'h0, 20'h0, 20'h0);

      // write path and illegal select
      drive(1'b0, 2'b01, 2'b01, 2'b00, 3'b011, 3'b001, 12'h3FF, 12'h0, 20'hABCDE, 20'h0);
      drive(1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b010, 12'h0, 12'h123, 20'h0, 20'h0);
      idle();

      // starvation guard: r0 locks forever, r1 arrives on the fourth cycle
      for (int i = 0; i < LM + 6; i++)
         drive(1'b0, {(i >= 3), 1'b1}, 2'b00, 2'b01, 3'b001, 3'b011,
               12'(i), 12'h700 + 12'(i), 20'h0, 20'h0);
      idle();

      // saturation with r1 idle, then r1 arrives
      for (int i = 0; i < LM + 4; i++)
         drive(1'b0, 2'b01, 2'b01, 2'b01, 3'b011, 3'b001, 12'(i), 12'h0, 20'(i * 3), 20'h0);
      for (int i = 0; i < 3; i++)
         drive(1'b0, 2'b11, 2'b01, 2'b01, 3'b011, 3'b001, 12'h0AA, 12'h0BB, 20'h1, 20'h2);
      idle();

      // reset in the cycle crd is high
      drive(1'b0, 2'b01, 2'b00, 2'b00, 3'b011, 3'b001, 12'h777, 12'h0, 20'h0, 20'h0);
      drive(1'b1, 2'b11, 2'b00, 2'b00, 3'b001, 3'b001, 12'h1, 12'h2, 20'h0, 20'h0);
      idle();
      idle();

      // randomized traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         rq = 2'($urandom_range(0, 3));
         we = 2'($urandom_range(0, 3));
         lk = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
         k  = $urandom_range(0, 9);
         s0 = (k < 5) ? 3'b001 : (k < 9) ? 3'b011 : 3'($urandom_range(0, 7));
         k  = $urandom_range(0, 9);
         s1 = (k < 5) ? 3'b011 : (k < 9) ? 3'b001 : 3'($urandom_range(0, 7));
         drive(($urandom_range(0, 99) == 0), rq, we, lk, s0, s1,
               12'($urandom), 12'($urandom), 20'($urandom), 20'($urandom));
      end

      repeat (4) idle();
      repeat (3) @(posedge clk);
      #3;
      check("cmd_q_drained", cmd_q.size(), 0);
      check("rd_q_drained", rd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
